// File: rtl/mulmod_arbiter_if.sv
// Bundle between mulmod_arbiter, its requesters and the shared mul64/mod units.
// master is the arbiter side; slave is the requesters plus the mul64/mod instances.
interface mulmod_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int GNT_W = 2
);
    // req_valid is a level held by a requester until its req_done pulse; a request
    // is accepted only when the arbiter is idle. *_enable and *_done are one-cycle
    // pulses, and a done pulse is honoured only while its unit is being waited on.
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*64-1:0] req_a;
    logic [NREQ*64-1:0] req_b;
    logic [NREQ-1:0]    req_done;
    logic               req_err;
    logic [63:0]        result;
    logic               busy;
    logic [GNT_W-1:0]   grant_id;
    logic               mul64_enable;
    logic [63:0]        mul64_mul1;
    logic [63:0]        mul64_mul2;
    logic               mul64_mul1_sign;
    logic               mul64_mul2_sign;
    logic               mul64_done;
    logic [127:0]       mul64_result;
    logic               mod_enable;
    logic [127:0]       mod_input;
    logic               mod_input_sign;
    logic               mod_done;
    logic [63:0]        mod_result;
    logic [1:0]         state;  // debug view of the scheduler FSM

    modport master (
        input  req_valid, req_a, req_b, mul64_done, mul64_result, mod_done, mod_result,
        output req_done, req_err, result, busy, grant_id,
        output mul64_enable, mul64_mul1, mul64_mul2, mul64_mul1_sign, mul64_mul2_sign,
        output mod_enable, mod_input, mod_input_sign, state
    );

    modport slave (
        output req_valid, req_a, req_b, mul64_done, mul64_result, mod_done, mod_result,
        input  req_done, req_err, result, busy, grant_id,
        input  mul64_enable, mul64_mul1, mul64_mul2, mul64_mul1_sign, mul64_mul2_sign,
        input  mod_enable, mod_input, mod_input_sign, state
    );
endinterface

// File: rtl/mulmod_arbiter.sv
// Round-robin scheduler sharing one mul64 and one mod unit between NREQ requesters.
// Optional MULMOD_ARB_TIMEOUT_EN aborts a job after TIMEOUT_CYC cycles without a done.
module mulmod_arbiter #(
    parameter int NREQ        = 4,
    parameter int GNT_W       = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst,
    mulmod_arbiter_if.master bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_MOD  = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [GNT_W-1:0] grant_q, grant_d, last_q, last_d;
    logic [63:0]      a_q, a_d, b_q, b_d, res_q, res_d;
    logic [127:0]     prod_q, prod_d;
    logic             mul_en_q, mul_en_d, mod_en_q, mod_en_d;
    logic             timeout;

    logic             found;
    logic [GNT_W-1:0] winner;
    logic [63:0]      sel_a, sel_b;

    // First requester at or after last+1, wrapping, so every requester waits at most NREQ-1 jobs.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int off = 1; off <= NREQ; off++) begin
            automatic int idx = (int'(last_q) + off) % NREQ;
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = GNT_W'(idx);
                sel_a  = bus.req_a[idx*64 +: 64];
                sel_b  = bus.req_b[idx*64 +: 64];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        a_d      = a_q;
        b_d      = b_q;
        prod_d   = prod_q;
        res_d    = res_q;
        mul_en_d = 1'b0;
        mod_en_d = 1'b0;
        case (state_q)
            S_IDLE: if (found) begin
                state_d  = S_MUL;
                grant_d  = winner;
                last_d   = winner;
                a_d      = sel_a;
                b_d      = sel_b;
                mul_en_d = 1'b1;
            end
            S_MUL: if (bus.mul64_done) begin
                prod_d   = bus.mul64_result;
                state_d  = S_MOD;
                mod_en_d = 1'b1;
            end else if (timeout) begin
                res_d   = '0;
                state_d = S_RESP;
            end
            S_MOD: if (bus.mod_done) begin
                res_d   = bus.mod_result;
                state_d = S_RESP;
            end else if (timeout) begin
                res_d   = '0;
                state_d = S_RESP;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef MULMOD_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    // Counter restarts on every state change, so MUL and MOD each get the full budget.
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || state_d != state_q) begin
            cnt_q <= '0;
        end else if (state_q == S_MUL || state_q == S_MOD) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= timeout && ((state_q == S_MUL && !bus.mul64_done) ||
                                 (state_q == S_MOD && !bus.mod_done));
        end
    end

    assign bus.req_err = err_q && (state_q == S_RESP);
`else
    assign timeout     = 1'b0;
    assign bus.req_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            last_q   <= GNT_W'(NREQ - 1);
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            res_q    <= '0;
            mul_en_q <= 1'b0;
            mod_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            a_q      <= a_d;
            b_q      <= b_d;
            prod_q   <= prod_d;
            res_q    <= res_d;
            mul_en_q <= mul_en_d;
            mod_en_q <= mod_en_d;
        end
    end

    assign bus.req_done        = (state_q == S_RESP) ? (NREQ'(1) << grant_q) : '0;
    assign bus.result          = (state_q == S_RESP) ? res_q : '0;
    assign bus.busy            = (state_q != S_IDLE);
    assign bus.grant_id        = grant_q;
    assign bus.mul64_enable    = mul_en_q;
    assign bus.mul64_mul1      = a_q;
    assign bus.mul64_mul2      = b_q;
    assign bus.mul64_mul1_sign = 1'b0;
    assign bus.mul64_mul2_sign = 1'b0;
    assign bus.mod_enable      = mod_en_q;
    assign bus.mod_input       = prod_q;
    assign bus.mod_input_sign  = 1'b0;
    assign bus.state           = state_q;
endmodule

// File: tb/tb_mulmod_arbiter.sv
// Self-checking bench for mulmod_arbiter: job-level model plus directed scenarios.
// Build with MULMOD_ARB_TIMEOUT_EN defined to include the timeout scenario.
module tb_mulmod_arbiter;
    localparam int          NREQ   = 4;
    localparam int          GNT_W  = 2;
    localparam int          TO_CYC = 8;
    localparam logic [63:0] P      = 64'hFFFF_FFFF_FFFF_FFC5;

    logic clk = 1'b0;
    logic rst;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    mulmod_arbiter_if #(.NREQ(NREQ), .GNT_W(GNT_W)) bus ();

    mulmod_arbiter #(.NREQ(NREQ), .GNT_W(GNT_W), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog run did not finish got=running want=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- mul64 / mod responder ----------------
    int           k_cfg = 1, m_cfg = 1;
    int           mul_due = -1, mod_due = -1, stray_mul = -1, stray_mod = -1;
    logic [127:0] prod_hold = '0;
    logic [63:0]  red_hold  = '0;

    always @(negedge clk) begin
        bus.mul64_done   = (cyc == mul_due) || (cyc == stray_mul);
        bus.mul64_result = (cyc == mul_due) ? prod_hold : {64'hDEAD_BEEF_0BAD_F00D, 64'(cyc)};
        bus.mod_done     = (cyc == mod_due) || (cyc == stray_mod);
        bus.mod_result   = (cyc == mod_due) ? red_hold : (64'hBAD0_0000_0000_0000 ^ 64'(cyc));
        if (bus.mul64_enable === 1'b1 && k_cfg > 0) begin
            mul_due   = cyc + k_cfg;
            prod_hold = {64'b0, bus.mul64_mul1} * {64'b0, bus.mul64_mul2};
        end
        if (bus.mod_enable === 1'b1 && m_cfg > 0) begin
            mod_due  = cyc + m_cfg;
            red_hold = 64'(bus.mod_input % {64'b0, P});
        end
    end

    int done_cnt = 0, mul_cnt = 0, mod_cnt = 0;
    always @(negedge clk) begin
        if (bus.req_done != '0) done_cnt++;
        if (bus.mul64_enable === 1'b1) mul_cnt++;
        if (bus.mod_enable === 1'b1) mod_cnt++;
    end

    // ---------------- job-level model and scoreboard ----------------
    logic [66:0]      exp_q[$];
    bit               jv = 1'b0;
    int               m_e, m_d, m_k, m_last, m_grant, next_arb, w;
    logic [63:0]      m_val;
    bit               m_err;
    logic [127:0]     m_prod;
    logic [NREQ-1:0]  exp_done;
    logic [66:0]      sb_exp;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            jv       = 1'b0;
            m_last   = NREQ - 1;
            m_grant  = 0;
            next_arb = cyc + 1;
            exp_q.delete();
        end else if (cyc >= next_arb && bus.req_valid != '0) begin
            w = (m_last + 1) % NREQ;
            while (!bus.req_valid[w]) w = (w + 1) % NREQ;
            m_grant = w;
            m_last  = w;
            m_e     = cyc;
            m_k     = k_cfg;
            jv      = 1'b1;
            m_prod  = {64'b0, bus.req_a[w*64 +: 64]} * {64'b0, bus.req_b[w*64 +: 64]};
            if (k_cfg < 0) begin
                m_d   = cyc + TO_CYC;
                m_val = '0;
                m_err = 1'b1;
            end else begin
                m_d   = cyc + k_cfg + m_cfg + 2;
                m_val = 64'(m_prod % {64'b0, P});
                m_err = 1'b0;
            end
            next_arb = m_d + 2;
            exp_q.push_back({m_err, GNT_W'(w), m_val});
        end
        #1;
        exp_done = '0;
        if (jv && cyc == m_d) exp_done[m_grant] = 1'b1;
        chk("busy", 128'(bus.busy), 128'(jv && cyc >= m_e && cyc <= m_d));
        chk("req_done", 128'(bus.req_done), 128'(exp_done));
        chk("result", 128'(bus.result), (jv && cyc == m_d) ? 128'(m_val) : 128'(0));
        chk("req_err", 128'(bus.req_err), 128'(jv && cyc == m_d && m_err));
        chk("grant_id", 128'(bus.grant_id), 128'(m_grant));
        chk("mul64_enable", 128'(bus.mul64_enable), 128'(jv && cyc == m_e));
        chk("mod_enable", 128'(bus.mod_enable), 128'(jv && !m_err && cyc == m_e + m_k + 1));
        chk("sign_ties", 128'({bus.mul64_mul1_sign, bus.mul64_mul2_sign, bus.mod_input_sign}), 128'(0));
        if (bus.req_done != '0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_done cyc=%0d got=%0h want=none", cyc, bus.req_done);
            end else begin
                sb_exp = exp_q.pop_front();
                chk("sb_job", 128'({bus.req_err, bus.grant_id, bus.result}), 128'(sb_exp));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_op(input int idx, input logic [63:0] a, input logic [63:0] b);
        bus.req_a[idx*64 +: 64] = a;
        bus.req_b[idx*64 +: 64] = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_done(input int budget, output logic [NREQ-1:0] vec, output logic [63:0] res,
                             output logic err, output logic [GNT_W-1:0] gid, output int at);
        vec = '0; res = '0; err = 1'b0; gid = '0; at = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (bus.req_done != '0) begin
                vec = bus.req_done;
                res = bus.result;
                err = bus.req_err;
                gid = bus.grant_id;
                at  = cyc;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_done cyc=%0d got=no_done want=done_within_%0d", cyc, budget);
    endtask

    // ---------------- directed scenarios ----------------
    logic [NREQ-1:0]  vec;
    logic [63:0]      res;
    logic             err;
    logic [GNT_W-1:0] gid;
    int               at, t0;
    int               rr_g[5]   = '{0, 1, 2, 3, 0};
    logic [63:0]      rr_r[5]   = '{64'd14, 64'd21, 64'd28, 64'd35, 64'd14};
    logic [NREQ-1:0]  onehot;

    initial begin
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_req_done", 128'(bus.req_done), 128'(0));
        chk("rst_result", 128'(bus.result), 128'(0));
        chk("rst_grant", 128'(bus.grant_id), 128'(0));
        chk("rst_mul_ops", 128'({bus.mul64_mul1, bus.mul64_mul2}), 128'(0));
        chk("rst_mod_input", bus.mod_input, 128'(0));
        rst = 1'b0;

        // single request, basic latency
        @(negedge clk);
        k_cfg = 3; m_cfg = 2;
        mul_cnt = 0; mod_cnt = 0;
        set_op(1, 64'd3, 64'd5);
        t0 = cyc;
        bus.req_valid = 4'b0010;
        wait_done(40, vec, res, err, gid, at);
        bus.req_valid = '0;
        chk("t1_vec", 128'(vec), 128'(4'b0010));
        chk("t1_result", 128'(res), 128'(15));
        chk("t1_grant", 128'(gid), 128'(1));
        chk("t1_latency", 128'(at - t0), 128'(8));
        repeat (3) @(negedge clk);
        chk("t1_mul_pulses", 128'(mul_cnt), 128'(1));
        chk("t1_mod_pulses", 128'(mod_cnt), 128'(1));

        // round robin with all requesters continuously requesting
        do_reset();
        k_cfg = 1; m_cfg = 1;
        for (int i = 0; i < NREQ; i++) set_op(i, 64'(i + 2), 64'd7);
        bus.req_valid = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_done(40, vec, res, err, gid, at);
            if (j == 4) bus.req_valid = '0;
            onehot = '0;
            onehot[rr_g[j]] = 1'b1;
            chk("t2_grant", 128'(gid), 128'(rr_g[j]));
            chk("t2_vec", 128'(vec), 128'(onehot));
            chk("t2_result", 128'(res), 128'(rr_r[j]));
        end

        // stray done pulses: mul64_done in IDLE, mod_done in MUL
        repeat (2) @(negedge clk);
        done_cnt = 0;
        stray_mul = cyc + 1;
        repeat (3) @(negedge clk);
        chk("t3_idle_busy", 128'(bus.busy), 128'(0));
        chk("t3_idle_no_done", 128'(done_cnt), 128'(0));
        k_cfg = 2; m_cfg = 2;
        set_op(3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        t0 = cyc;
        stray_mod = cyc + 2;
        bus.req_valid = 4'b1000;
        wait_done(40, vec, res, err, gid, at);
        bus.req_valid = '0;
        chk("t3_vec", 128'(vec), 128'(4'b1000));
        chk("t3_result", 128'(res), 128'(116));
        chk("t3_latency", 128'(at - t0), 128'(7));

        // reset while in MOD, stale mod_done arrives afterwards
        repeat (2) @(negedge clk);
        k_cfg = 2; m_cfg = 5;
        set_op(2, 64'd11, 64'd13);
        bus.req_valid = 4'b0100;
        repeat (5) @(negedge clk);
        chk("t4_busy_in_mod", 128'(bus.busy), 128'(1));
        rst = 1'b1;
        bus.req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (6) @(negedge clk);
        chk("t4_idle_busy", 128'(bus.busy), 128'(0));
        chk("t4_no_done", 128'(done_cnt), 128'(0));
        chk("t4_grant_cleared", 128'(bus.grant_id), 128'(0));
        k_cfg = 1; m_cfg = 1;
        bus.req_valid = 4'b1111;
        wait_done(40, vec, res, err, gid, at);
        bus.req_valid = '0;
        chk("t4_next_grant", 128'(gid), 128'(0));
        chk("t4_next_result", 128'(res), 128'(14));

        // request withdrawn after grant still completes
        repeat (2) @(negedge clk);
        k_cfg = 2; m_cfg = 1;
        set_op(2, 64'd1234567, 64'd89);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        bus.req_valid = '0;
        set_op(2, 64'h1111_2222_3333_4444, 64'h5555);
        wait_done(40, vec, res, err, gid, at);
        chk("t5_vec", 128'(vec), 128'(4'b0100));
        chk("t5_result", 128'(res), 128'(109876463));

`ifdef MULMOD_ARB_TIMEOUT_EN
        // mul64_done never arrives
        repeat (2) @(negedge clk);
        k_cfg = -1;
        set_op(0, 64'd9, 64'd9);
        t0 = cyc;
        bus.req_valid = 4'b0001;
        wait_done(40, vec, res, err, gid, at);
        bus.req_valid = '0;
        chk("t6_vec", 128'(vec), 128'(4'b0001));
        chk("t6_err", 128'(err), 128'(1));
        chk("t6_result", 128'(res), 128'(0));
        chk("t6_latency", 128'(at - t0), 128'(TO_CYC + 1));
        repeat (2) @(negedge clk);
        chk("t6_idle", 128'(bus.busy), 128'(0));
        k_cfg = 1;
`endif

        repeat (4) @(negedge clk);
        chk("sb_drained", 128'(exp_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mulmod_arbiter.md
Name: mulmod_arbiter

Overview:
- Round-robin scheduler that shares the single 64x64 multiplier (mul64) and the single modular reducer (mod) between NREQ requesters, e.g. the modular inverter and the point add/double units.
- Each granted request runs as mul64 (a*b, 128-bit), then mod (product mod p), and returns the 64-bit residue to the granted requester.
- Sits between the ECC arithmetic units and the shared mul64/mod instances, and drives their enable/operand pins in place of the individual units.

Parameters:
NREQ, 4, number of requesters (2..8)
GNT_W, 2, width of grant index (>= clog2(NREQ))
TIMEOUT_CYC, 255, max cycles waited for mul64_done/mod_done (used only with MULMOD_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock; single clock domain
rst  in  1  reset, synchronous, active-high
req_valid  in  NREQ  per-requester request level
req_a  in  NREQ*64  operand A, requester i at [64*i+63:64*i], unsigned
req_b  in  NREQ*64  operand B, same packing
req_done  out  NREQ  one-hot, one-cycle completion pulse
req_err  out  1  one-cycle timeout pulse, coincident with req_done
result  out  64  residue, valid only in the req_done cycle
busy  out  1  high in every state except IDLE
grant_id  out  GNT_W  index of the requester currently served
mul64_enable  out  1  one-cycle start pulse to mul64
mul64_mul1  out  64  latched operand A
mul64_mul2  out  64  latched operand B
mul64_mul1_sign  out  1  tied 0
mul64_mul2_sign  out  1  tied 0
mul64_done  in  1  mul64 completion pulse
mul64_result  in  128  product
mod_enable  out  1  one-cycle start pulse to mod
mod_input  out  128  latched product
mod_input_sign  out  1  tied 0
mod_done  in  1  mod completion pulse
mod_result  in  64  reduced value

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE; all outputs 0.
  - Operand/product/result registers cleared to 0.
  - Round-robin pointer last=NREQ-1, so requester 0 wins first.
  - Reset mid-operation abandons the job. No req_done is issued. A late mul64_done/mod_done from the abandoned job is ignored because it arrives in IDLE.
- States: IDLE, MUL, MOD, RESP.
- IDLE:
  - If any req_valid is high, select the first set bit searching from (last+1) mod NREQ upward with wrap.
  - Latch that requester's req_a/req_b, set grant_id and last to the winner, go to MUL.
  - With no requests, stay in IDLE.
- MUL:
  - mul64_enable=1 in the first MUL cycle only.
  - On mul64_done: latch mul64_result, go to MOD.
- MOD:
  - mod_enable=1 in the first MOD cycle only.
  - mod_input is driven from the product register.
  - On mod_done: latch mod_result, go to RESP.
- RESP:
  - req_done[grant_id]=1 and result=latched residue, for exactly one cycle.
  - Next state is IDLE.
- Done sampling: mul64_done is sampled only in MUL and mod_done only in MOD. Done pulses in any other state are ignored, as is a done pulse for the other unit.
- Latency: request sampled in IDLE at cycle T; mul64_done arrives k>=1 cycles after mul64_enable; mod_done arrives m>=1 cycles after mod_enable. req_done is then high at cycle T+k+m+3.
- Requester protocol:
  - Hold req_valid high until req_done is seen. Operands need only be stable in the grant cycle.
  - req_valid still high in the cycle after req_done is treated as a new request.
  - Dropping req_valid after grant does not cancel the job; req_done still pulses.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,..,NREQ-1,0. No requester waits more than NREQ-1 jobs.
- Simultaneous new req_valid during a job: it waits; arbitration happens only in IDLE.
- Minimum gap between back-to-back jobs is one IDLE cycle after RESP.

Optional Feature:
MULMOD_ARB_TIMEOUT_EN
- Defined:
  - A counter runs in MUL and MOD, cleared on state entry.
  - If the counter reaches TIMEOUT_CYC without the expected done, go to RESP.
  - In that RESP cycle: req_done[grant_id]=1, req_err=1, result=0.
  - A done pulse from the stale job that arrives later is ignored.
- Undefined: no counter; MUL and MOD wait indefinitely; req_err is tied 0.

Test Plan:
1. Single request, basic latency: requester 1 sends a=3, b=5; model answers mul64 k=3 cycles later (result 15) and mod m=2 cycles later (mod_result 15). Required: req_done=4'b0010 at T+8, result=15, grant_id=1, one pulse each of mul64_enable and mod_enable.
2. Round robin: all four req_valid held high through four jobs. Required grant order 0,1,2,3, then 0 again; each req_done is one-hot and matches grant_id.
3. Stray done pulses: mul64_done pulsed during IDLE, mod_done pulsed during MUL. Required: no state change and no req_done; the job completes normally on the real done pulses.
4. Reset mid-job: rst asserted for 1 cycle while in MOD, then the old mod_done arrives. Required: state IDLE, all outputs 0, no req_done; the next grant goes to requester 0.
5. Withdrawn request: req_valid[2] dropped one cycle after grant. Required: req_done[2] still pulses with the correct residue.
6. Timeout (macro defined, TIMEOUT_CYC=8): mul64_done never arrives. Required: req_done and req_err high 8 cycles after MUL entry, result=0, then IDLE.
